// File: rtl/mem_ntv_arbiter_pkg.sv
// mem_ntv_arbiter_pkg: shared owner/state enums and counter widths for the native memory arbiter
package mem_ntv_arbiter_pkg;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;
    typedef enum logic {IDLE, RD_WAIT} state_t;
    localparam int LAT_W = 3;
    localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_ntv_arbiter_if.sv
// mem_ntv_arbiter_if: native memory bus between the arbiter (core) and the memory (mem)
interface mem_ntv_arbiter_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [3:0]  mem_byteenable;
    modport core(output mem_addr, mem_wdata, mem_w_en, mem_r_en, mem_byteenable, input mem_rdata);
    modport mem(input mem_addr, mem_wdata, mem_w_en, mem_r_en, mem_byteenable, output mem_rdata);
endinterface

// File: rtl/mem_ntv_latency_ctr.sv
// mem_ntv_latency_ctr: read latency down-counter, done flags the cycle read data is valid
module mem_ntv_latency_ctr
    import mem_ntv_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    logic [LAT_W-1:0] lat_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lat_cnt <= '0;
        else if (load) lat_cnt <= LAT_W'(RD_LATENCY);
        else if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
    assign done = lat_cnt == LAT_W'(1);
endmodule

// File: rtl/mem_ntv_arbiter.sv
// mem_ntv_arbiter: fetch/data arbiter onto a native memory port with fetch anti-starvation
module mem_ntv_arbiter
    import mem_ntv_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    mem_ntv_arbiter_if.core mem
);
    state_t state;
    owner_t owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic done, rvalid, cap, fetch_win, rd_gnt;
    mem_ntv_latency_ctr #(.RD_LATENCY(RD_LATENCY)) u_lat (
        .clk(clk),
        .rst_n(rst_n),
        .load(rd_gnt),
        .done(done)
    );
    // grants are also gated by rst_n so every output is 0 while reset is held
    assign rvalid = state == RD_WAIT && done;
    assign cap = rst_n && (state == IDLE || rvalid);
    assign fetch_win = i_req && (!d_req || starve_cnt == STARVE_W'(MAX_WAIT));
    assign i_gnt = cap && fetch_win;
    assign d_gnt = cap && d_req && !fetch_win;
    assign rd_gnt = i_gnt || (d_gnt && !d_we);
    assign i_rvalid = rvalid && owner == OWN_FETCH;
    assign d_rvalid = rvalid && owner == OWN_DATA;
    assign i_rdata = i_rvalid ? mem.mem_rdata : '0;
    assign d_rdata = d_rvalid ? mem.mem_rdata : '0;
    assign mem.mem_addr = i_gnt ? i_addr : d_gnt ? d_addr : '0;
    assign mem.mem_wdata = d_gnt ? d_wdata : '0;
    assign mem.mem_w_en = d_gnt && d_we;
    assign mem.mem_r_en = rd_gnt;
    assign mem.mem_byteenable = i_gnt ? 4'hF : d_gnt ? d_be : 4'h0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_FETCH;
            starve_cnt <= '0;
        end else begin
            if (rd_gnt) begin
                state <= RD_WAIT;
                owner <= i_gnt ? OWN_FETCH : OWN_DATA;
            end else if (rvalid) state <= IDLE;
            starve_cnt <= i_gnt ? '0
                        : (cap && i_req && starve_cnt != STARVE_W'(MAX_WAIT)) ? starve_cnt + 1'b1
                        : starve_cnt;
        end
endmodule

// File: tb/tb_mem_ntv_arbiter.sv
// tb_mem_ntv_arbiter: directed and randomized checks of mem_ntv_arbiter against a cycle-stamp model
module tb_mem_ntv_arbiter;
    localparam int MW = 4;
    logic clk = 0;
    logic rst_n = 0;
    logic i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, rdata;
    logic [3:0] d_be;
    logic a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid;
    logic b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
    logic [31:0] a_i_rdata, a_d_rdata, b_i_rdata, b_d_rdata;
    int n_tests = 0;
    int n_fail = 0;
    bit sel;
    int lat, cyc, due, starve;
    bit pend, pown, e_cap, e_rv, e_ig, e_dg;
    mem_ntv_arbiter_if ma();
    mem_ntv_arbiter_if mb();
    assign ma.mem_rdata = rdata;
    assign mb.mem_rdata = rdata;
    always #5 clk = ~clk;
    mem_ntv_arbiter #(.RD_LATENCY(1), .MAX_WAIT(MW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .mem(ma)
    );
    mem_ntv_arbiter #(.RD_LATENCY(3), .MAX_WAIT(MW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .mem(mb)
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    function automatic logic [1:0] obs_gnt();
        return sel ? {b_i_gnt, b_d_gnt} : {a_i_gnt, a_d_gnt};
    endfunction
    function automatic logic [65:0] obs_rv();
        return sel ? {b_i_rvalid, b_d_rvalid, b_i_rdata, b_d_rdata}
                   : {a_i_rvalid, a_d_rvalid, a_i_rdata, a_d_rdata};
    endfunction
    function automatic logic [72:0] obs_mem();
        return sel ? {mb.mem_addr, mb.mem_wdata, mb.mem_w_en, mb.mem_r_en, mb.mem_byteenable}
                   : {ma.mem_addr, ma.mem_wdata, ma.mem_w_en, ma.mem_r_en, ma.mem_byteenable};
    endfunction
    // model: a pending read is a cycle stamp at which its data is due
    task automatic sample();
        logic fw;
        @(negedge clk);
        e_rv = rst_n && pend && cyc == due;
        e_cap = rst_n && (!pend || e_rv);
        fw = i_req && (!d_req || starve == MW);
        e_ig = e_cap && fw;
        e_dg = e_cap && d_req && !fw;
        check("gnt", obs_gnt(), {e_ig, e_dg});
        check("rvalid", obs_rv(), {e_rv && !pown, e_rv && pown,
              (e_rv && !pown) ? rdata : 32'h0, (e_rv && pown) ? rdata : 32'h0});
        check("mem", obs_mem(), {e_ig ? i_addr : e_dg ? d_addr : 32'h0, e_dg ? d_wdata : 32'h0,
              e_dg && d_we, e_ig || (e_dg && !d_we), e_ig ? 4'hF : e_dg ? d_be : 4'h0});
    endtask
    task automatic advance();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend = 0;
            starve = 0;
        end else begin
            starve = e_ig ? 0 : (e_cap && i_req && starve < MW) ? starve + 1 : starve;
            if (e_ig || (e_dg && !d_we)) begin
                pend = 1;
                due = cyc + lat;
                pown = e_dg;
            end else if (e_rv) pend = 0;
        end
        cyc++;
    endtask
    task automatic do_reset(input bit s);
        sel = s;
        lat = s ? 3 : 1;
        rst_n = 0;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        sample(); advance(); sample(); advance();
        rst_n = 1;
    endtask
    initial begin
        rdata = 0; cyc = 0; pend = 0; pown = 0; starve = 0; due = 0;
        do_reset(0);
        i_req = 1; i_addr = 32'h100;
        sample();
        check("t1_gnt_ren", {a_i_gnt, ma.mem_r_en}, 2'b11);
        advance();
        i_req = 0; rdata = 32'hDEADBEEF;
        sample();
        check("t1_rdata", {a_i_rvalid, a_i_rdata}, {1'b1, 32'hDEADBEEF});
        advance();
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
        sample();
        check("t2_store", {ma.mem_w_en, ma.mem_byteenable}, {1'b1, 4'b0011});
        advance();
        d_we = 0; d_addr = 32'h2004; d_be = 4'hF;
        sample();
        check("t2_ready", {a_d_gnt, a_d_rvalid}, 2'b10);
        advance();
        d_req = 0;
        sample(); advance();
        i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h3000;
        sample();
        check("t3_dfirst", {a_i_gnt, a_d_gnt}, 2'b01);
        advance();
        d_req = 0;
        sample();
        check("t3_b2b", {a_d_rvalid, a_i_gnt}, 2'b11);
        advance();
        i_req = 0;
        sample();
        check("t3_irv", a_i_rvalid, 1'b1);
        advance();
        i_req = 1; d_req = 1; d_we = 1;
        for (int k = 1; k <= 5; k++) begin
            sample();
            check("t4_starve", a_i_gnt, k == 5);
            advance();
        end
        check("t4_cnt", dut_a.starve_cnt, 0);
        i_req = 0; d_req = 0; d_we = 0;
        sample(); advance();
        do_reset(1);
        d_req = 1; d_addr = 32'h40;
        sample();
        check("t5_dgnt", b_d_gnt, 1'b1);
        advance();
        d_req = 0; rst_n = 0; i_req = 1; i_addr = 32'h300;
        sample();
        check("t5_rst_out", {obs_gnt(), obs_rv()}, 0);
        check("t5_rst_mem", obs_mem(), 0);
        advance(); sample(); advance();
        rst_n = 1;
        sample();
        check("t5_first", b_i_gnt, 1'b1);
        advance();
        i_req = 0; rdata = 32'hCAFEF00D;
        for (int k = 1; k <= 3; k++) begin
            sample();
            check("t5_lat", {b_i_rvalid, b_d_rvalid}, {k == 3, 1'b0});
            advance();
        end
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int n = 0; n < 1500; n++) begin
                sample();
                advance();
                if (e_ig) i_req = 0;
                if (e_dg) d_req = 0;
                if (!i_req && $urandom_range(0, 3) == 0) begin
                    i_req = 1;
                    i_addr = $urandom;
                end
                if (!d_req && $urandom_range(0, 1) == 0) begin
                    d_req = 1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = $urandom;
                    d_wdata = $urandom;
                    d_be = 4'($urandom);
                end
                rdata = $urandom;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
